// File: rtl/ram_arb_pkg.sv
// Shared types for the two-client RAM arbiter: lock FSM states and read-return owner tags.
package ram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      C0   = 2'd1,
      C1   = 2'd2
   } owner_t;

   // Owner tag of whichever client holds the grant this cycle.
   function automatic owner_t owner_of(input logic gnt0);
      return gnt0 ? C0 : C1;
   endfunction

endpackage

// File: rtl/ram_if.sv
// Single-port RAM access interface: requester drives en/addr/we/be/data_w, memory answers delay/data_r.
interface Ram_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                    en;
   logic [ADDR_WIDTH-1:0]   addr;
   logic                    we;
   logic [DATA_WIDTH/8-1:0] be;
   logic [DATA_WIDTH-1:0]   data_w;
   logic [DATA_WIDTH-1:0]   data_r;
   logic                    delay;

   modport memory (
      input  en, addr, we, be, data_w,
      output data_r, delay
   );

   modport client (
      output en, addr, we, be, data_w,
      input  data_r, delay
   );
endinterface

// File: rtl/ram_arb_pick2.sv
// Combinational grant decision between two RAM clients; a held lock overrides arbitration.
module ram_arb_pick2
   import ram_arb_pkg::*;
#(
   parameter int FIXED_PRIO = 0
) (
   input  logic   i_en0,
   input  logic   i_en1,
   input  owner_t i_rr_last,
   input  state_t i_state,
   output logic   o_gnt0,
   output logic   o_gnt1
);

   logic w_tie_to0;

   // On a tie cl0 wins unless it was the last one served (and priority is not fixed).
   assign w_tie_to0 = (FIXED_PRIO != 0) || (i_rr_last != C0);

   always_comb begin
      o_gnt0 = 1'b0;
      o_gnt1 = 1'b0;
      if ((i_state == LOCK0) && i_en0) begin
         o_gnt0 = 1'b1;
      end else if ((i_state == LOCK1) && i_en1) begin
         o_gnt1 = 1'b1;
      end else if (i_en0 && i_en1) begin
         o_gnt0 = w_tie_to0;
         o_gnt1 = !w_tie_to0;
      end else if (i_en0) begin
         o_gnt0 = 1'b1;
      end else if (i_en1) begin
         o_gnt1 = 1'b1;
      end
   end

endmodule

// File: rtl/ram_arbiter2.sv
// Two-client arbiter in front of one single-port RAM: grant muxing, stall locking and read-data return.
module ram_arbiter2
   import ram_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int FIXED_PRIO = 0
) (
   input  logic   clk,
   input  logic   resetb,
   Ram_if.memory  cl0,
   Ram_if.memory  cl1,
   Ram_if.client  mem
);

   state_t r_state;
   state_t w_state_next;
   owner_t r_rr_last;
   owner_t w_rr_next;
   owner_t r_rd_owner;
   owner_t w_owner_next;

   logic                    w_pick0;
   logic                    w_pick1;
   logic                    w_gnt0;
   logic                    w_gnt1;
   logic                    w_done;
   logic                    w_mem_en;
   logic [ADDR_WIDTH-1:0]   w_mem_addr;
   logic                    w_mem_we;
   logic [DATA_WIDTH/8-1:0] w_mem_be;
   logic [DATA_WIDTH-1:0]   w_mem_data_w;
   logic                    w_delay0;
   logic                    w_delay1;
   logic [DATA_WIDTH-1:0]   w_data_r0;
   logic [DATA_WIDTH-1:0]   w_data_r1;

   ram_arb_pick2 #(
      .FIXED_PRIO (FIXED_PRIO)
   ) u_pick (
      .i_en0     (cl0.en),
      .i_en1     (cl1.en),
      .i_rr_last (r_rr_last),
      .i_state   (r_state),
      .o_gnt0    (w_pick0),
      .o_gnt1    (w_pick1)
   );

   // Nothing reaches the RAM while reset is held, even if clients keep requesting.
   assign w_gnt0 = w_pick0 & resetb;
   assign w_gnt1 = w_pick1 & resetb;
   assign w_done = w_mem_en & !mem.delay;

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         r_state    <= IDLE;
         r_rr_last  <= C1;
         r_rd_owner <= NONE;
      end else begin
         r_state    <= w_state_next;
         r_rr_last  <= w_rr_next;
         r_rd_owner <= w_owner_next;
      end
   end

   always_comb begin
      w_state_next = IDLE;
      if (w_gnt0 && mem.delay) begin
         w_state_next = LOCK0;
      end else if (w_gnt1 && mem.delay) begin
         w_state_next = LOCK1;
      end
      w_rr_next    = r_rr_last;
      w_owner_next = NONE;
      if (w_done) begin
         w_rr_next = owner_of(w_gnt0);
         if (!w_mem_we) begin
            w_owner_next = owner_of(w_gnt0);
         end
      end
   end

   always_comb begin
      w_mem_en     = 1'b0;
      w_mem_addr   = '0;
      w_mem_we     = 1'b0;
      w_mem_be     = '0;
      w_mem_data_w = '0;
      w_delay0     = cl0.en;
      w_delay1     = cl1.en;
      if (w_gnt0) begin
         w_mem_en     = 1'b1;
         w_mem_addr   = cl0.addr;
         w_mem_we     = cl0.we;
         w_mem_be     = cl0.be;
         w_mem_data_w = cl0.data_w;
         w_delay0     = mem.delay;
      end else if (w_gnt1) begin
         w_mem_en     = 1'b1;
         w_mem_addr   = cl1.addr;
         w_mem_we     = cl1.we;
         w_mem_be     = cl1.be;
         w_mem_data_w = cl1.data_w;
         w_delay1     = mem.delay;
      end
      // Return routing follows the registered owner, not the grant of this cycle.
      w_data_r0 = (r_rd_owner == C0) ? mem.data_r : '0;
      w_data_r1 = (r_rd_owner == C1) ? mem.data_r : '0;
   end

   assign mem.en     = w_mem_en;
   assign mem.addr   = w_mem_addr;
   assign mem.we     = w_mem_we;
   assign mem.be     = w_mem_be;
   assign mem.data_w = w_mem_data_w;
   assign cl0.delay  = w_delay0;
   assign cl1.delay  = w_delay1;
   assign cl0.data_r = w_data_r0;
   assign cl1.data_r = w_data_r1;

   a_lock0_held : assert property (@(posedge clk) disable iff (!resetb) (r_state == LOCK0) |-> cl0.en);
   a_lock1_held : assert property (@(posedge clk) disable iff (!resetb) (r_state == LOCK1) |-> cl1.en);

endmodule

// File: tb/tb_ram_arbiter2.sv
// Directed-vector bench for ram_arbiter2: stimulus rows queue their expected outputs, a negedge monitor checks them.
module tb_ram_arbiter2;

   typedef struct {
      logic        rst;
      logic        e0;
      logic [31:0] a0;
      logic        w0;
      logic        e1;
      logic [31:0] a1;
      logic        w1;
      logic        md;
      logic        xen;
      logic [31:0] xaddr;
      logic        xwe;
      logic [31:0] xdw;
      logic [3:0]  xbe;
      logic        xd0;
      logic        xd1;
      logic [31:0] xr0;
      logic [31:0] xr1;
   } vec_t;

   localparam logic [31:0] DW0 = 32'h1111_1111;
   localparam logic [31:0] DW1 = 32'h2222_2222;
   localparam logic [3:0]  BE0 = 4'hF;
   localparam logic [3:0]  BE1 = 4'h3;

   logic clk    = 1'b0;
   logic resetb = 1'b0;
   logic md     = 1'b0;
   logic cnt_on = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;
   int cnt_a0 = 0, cnt_a1 = 0;
   int cnt_b0 = 0, cnt_b1 = 0, cnt_b1_dly = 0;

   vec_t stim_q[$];
   vec_t exp_q[$];
   int   idx_q[$];

   always #5 clk = ~clk;

   Ram_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) a0 ();
   Ram_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) a1 ();
   Ram_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) am ();
   Ram_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b0 ();
   Ram_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b1 ();
   Ram_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bm ();

   ram_arbiter2 #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIO(0)) u_dut_rr (
      .clk    (clk),
      .resetb (resetb),
      .cl0    (a0),
      .cl1    (a1),
      .mem    (am)
   );

   ram_arbiter2 #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIO(1)) u_dut_fx (
      .clk    (clk),
      .resetb (resetb),
      .cl0    (b0),
      .cl1    (b1),
      .mem    (bm)
   );

   // The fixed-priority instance sees the same client traffic and a never-stalling RAM.
   assign b0.en     = a0.en;
   assign b0.addr   = a0.addr;
   assign b0.we     = a0.we;
   assign b0.be     = a0.be;
   assign b0.data_w = a0.data_w;
   assign b1.en     = a1.en;
   assign b1.addr   = a1.addr;
   assign b1.we     = a1.we;
   assign b1.be     = a1.be;
   assign b1.data_w = a1.data_w;
   assign bm.delay  = 1'b0;
   assign bm.data_r = 32'h0;
   assign am.delay  = md;

   // RAM contents: word at address a reads as 0xA500_0000 | a; a junk word otherwise.
   always @(posedge clk) begin
      if (am.en && !am.delay && !am.we) am.data_r <= 32'hA500_0000 | am.addr;
      else                              am.data_r <= 32'hDEAD_BEEF;
   end

   task automatic row(input logic rst, input logic e0, input logic [31:0] ad0, input logic w0,
                      input logic e1, input logic [31:0] ad1, input logic w1, input logic mdel,
                      input logic xen, input logic [31:0] xaddr, input logic xwe,
                      input logic [31:0] xdw, input logic [3:0] xbe, input logic xd0, input logic xd1,
                      input logic [31:0] xr0, input logic [31:0] xr1);
      vec_t v;
      v.rst = rst;  v.e0 = e0;  v.a0 = ad0;  v.w0 = w0;
      v.e1 = e1;    v.a1 = ad1; v.w1 = w1;   v.md = mdel;
      v.xen = xen;  v.xaddr = xaddr; v.xwe = xwe; v.xdw = xdw; v.xbe = xbe;
      v.xd0 = xd0;  v.xd1 = xd1; v.xr0 = xr0; v.xr1 = xr1;
      stim_q.push_back(v);
   endtask

   task automatic idle(input logic [31:0] xr0, input logic [31:0] xr1);
      row(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0,
          1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, xr0, xr1);
   endtask

   // Monitor: one queued expectation per cycle, checked mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         vec_t e;
         int   k;
         e = exp_q.pop_front();
         k = idx_q.pop_front();
         n_cmp++;
         if (am.en !== e.xen || am.addr !== e.xaddr || am.we !== e.xwe || am.data_w !== e.xdw ||
             am.be !== e.xbe || a0.delay !== e.xd0 || a1.delay !== e.xd1 ||
             a0.data_r !== e.xr0 || a1.data_r !== e.xr1) begin
            n_bad++;
            $display("FAIL row%0d: got en=%b addr=%h we=%b dw=%h be=%h d0=%b d1=%b r0=%h r1=%h, want en=%b addr=%h we=%b dw=%h be=%h d0=%b d1=%b r0=%h r1=%h",
                     k, am.en, am.addr, am.we, am.data_w, am.be, a0.delay, a1.delay, a0.data_r, a1.data_r,
                     e.xen, e.xaddr, e.xwe, e.xdw, e.xbe, e.xd0, e.xd1, e.xr0, e.xr1);
         end else begin
            $display("row%0d ok: en=%b addr=%h we=%b d0=%b d1=%b r0=%h r1=%h",
                     k, am.en, am.addr, am.we, a0.delay, a1.delay, a0.data_r, a1.data_r);
         end
      end
      if (cnt_on) begin
         if (am.en && am.addr == 32'h60) cnt_a0++;
         if (am.en && am.addr == 32'h70) cnt_a1++;
         if (bm.en && bm.addr == 32'h60) cnt_b0++;
         if (bm.en && bm.addr == 32'h70) cnt_b1++;
         if (b1.delay) cnt_b1_dly++;
      end
   end

   task automatic check_cnt(input string name, input int got, input int want);
      n_cmp++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end else begin
         $display("%s ok: %0d", name, got);
      end
   endtask

   initial begin
      a0.en = 1'b0; a0.addr = 32'h0; a0.we = 1'b0; a0.be = BE0; a0.data_w = DW0;
      a1.en = 1'b0; a1.addr = 32'h0; a1.we = 1'b0; a1.be = BE1; a1.data_w = DW1;

      // reset held, no requests
      row(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      row(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      // both read after reset: cl0 first, cl1 next, data returned in order
      row(1'b1, 1'b1, 32'h20, 1'b0, 1'b1, 32'h30, 1'b0, 1'b0, 1'b1, 32'h20, 1'b0, DW0, BE0, 1'b0, 1'b1, 32'h0, 32'h0);
      row(1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h30, 1'b0, 1'b0, 1'b1, 32'h30, 1'b0, DW1, BE1, 1'b0, 1'b0, 32'hA500_0020, 32'h0);
      idle(32'h0, 32'hA500_0030);
      // cl0 alone
      row(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0, DW0, BE0, 1'b0, 1'b0, 32'h0, 32'h0);
      idle(32'hA500_0010, 32'h0);
      // cl0 read then cl1 write during the return cycle
      row(1'b1, 1'b1, 32'h14, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h14, 1'b0, DW0, BE0, 1'b0, 1'b0, 32'h0, 32'h0);
      row(1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h18, 1'b1, 1'b0, 1'b1, 32'h18, 1'b1, DW1, BE1, 1'b0, 1'b0, 32'hA500_0014, 32'h0);
      idle(32'h0, 32'h0);
      // 8 cycles of continuous contention: strict alternation
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0)
            row(1'b1, 1'b1, 32'h60, 1'b0, 1'b1, 32'h70, 1'b0, 1'b0, 1'b1, 32'h60, 1'b0, DW0, BE0, 1'b0, 1'b1,
                32'h0, (i == 0) ? 32'h0 : 32'hA500_0070);
         else
            row(1'b1, 1'b1, 32'h60, 1'b0, 1'b1, 32'h70, 1'b0, 1'b0, 1'b1, 32'h70, 1'b0, DW1, BE1, 1'b1, 1'b0,
                32'hA500_0060, 32'h0);
      end
      idle(32'h0, 32'hA500_0070);
      // cl1 write stalled 3 cycles; cl0 arrives in cycle 2 and waits for release
      row(1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h80, 1'b1, 1'b1, 1'b1, 32'h80, 1'b1, DW1, BE1, 1'b0, 1'b1, 32'h0, 32'h0);
      row(1'b1, 1'b1, 32'h90, 1'b0, 1'b1, 32'h80, 1'b1, 1'b1, 1'b1, 32'h80, 1'b1, DW1, BE1, 1'b1, 1'b1, 32'h0, 32'h0);
      row(1'b1, 1'b1, 32'h90, 1'b0, 1'b1, 32'h80, 1'b1, 1'b1, 1'b1, 32'h80, 1'b1, DW1, BE1, 1'b1, 1'b1, 32'h0, 32'h0);
      row(1'b1, 1'b1, 32'h90, 1'b0, 1'b1, 32'h80, 1'b1, 1'b0, 1'b1, 32'h80, 1'b1, DW1, BE1, 1'b1, 1'b0, 32'h0, 32'h0);
      row(1'b1, 1'b1, 32'h90, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h90, 1'b0, DW0, BE0, 1'b0, 1'b0, 32'h0, 32'h0);
      idle(32'hA500_0090, 32'h0);
      // cl0 served last, then locked; reset mid-lock; first tie afterwards goes to cl0
      row(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h40, 1'b0, DW0, BE0, 1'b0, 1'b0, 32'h0, 32'h0);
      row(1'b1, 1'b1, 32'h44, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h44, 1'b0, DW0, BE0, 1'b1, 1'b0, 32'hA500_0040, 32'h0);
      row(1'b1, 1'b1, 32'h44, 1'b0, 1'b1, 32'h50, 1'b0, 1'b1, 1'b1, 32'h44, 1'b0, DW0, BE0, 1'b1, 1'b1, 32'h0, 32'h0);
      row(1'b0, 1'b1, 32'h44, 1'b0, 1'b1, 32'h50, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0, 32'h0);
      row(1'b1, 1'b1, 32'h44, 1'b0, 1'b1, 32'h50, 1'b0, 1'b0, 1'b1, 32'h44, 1'b0, DW0, BE0, 1'b0, 1'b1, 32'h0, 32'h0);
      idle(32'hA500_0044, 32'h0);
      idle(32'h0, 32'h0);

      for (int i = 0; i < stim_q.size(); i++) begin
         vec_t v;
         v = stim_q[i];
         @(posedge clk);
         #1;
         resetb  = v.rst;
         a0.en   = v.e0;
         a0.addr = v.a0;
         a0.we   = v.w0;
         a1.en   = v.e1;
         a1.addr = v.a1;
         a1.we   = v.w1;
         md      = v.md;
         cnt_on  = (i >= 10) && (i < 18);
         exp_q.push_back(v);
         idx_q.push_back(i);
      end

      begin
         int guard;
         guard = 0;
         while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
         end
         @(posedge clk);
         #1;
         cnt_on = 1'b0;
         if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
         end
      end

      check_cnt("rr_cl0_grants", cnt_a0, 4);
      check_cnt("rr_cl1_grants", cnt_a1, 4);
      check_cnt("fixed_cl0_grants", cnt_b0, 8);
      check_cnt("fixed_cl1_grants", cnt_b1, 0);
      check_cnt("fixed_cl1_delayed", cnt_b1_dly, 8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
